cnt_seq_ctrl: RTL
=================

Name: cnt_seq_ctrl

Overview:
Upstream controller for the loadable up-counter stage. It accepts a timing request (start value, limit, mode) over a valid/ready handshake. It then drives the counter's load, enab and cnt_in pins, watches the counter's cnt_out, and signals completion. In periodic mode it reloads and repeats until aborted. It also tracks how many periods have completed.

Parameters:
WIDTH, 5, width of counter value (cnt_in/cnt_out/start/limit)
PCNT_W, 4, width of completed-period counter (saturating)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset; also tied to the counter stage's rst
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (IDLE only)
req_start  input  WIDTH  value loaded into counter
req_limit  input  WIDTH  terminal count value
req_periodic  input  1  1 = reload and repeat after each done; 0 = one-shot
abort  input  1  stop current operation
tick  input  1  count strobe; counter advances only on tick cycles
cnt_out  input  WIDTH  registered value from counter stage
load  output  1  counter load strobe
enab  output  1  counter increment enable
cnt_in  output  WIDTH  load value to counter (registered start value)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when limit reached
aborted  output  1  one-cycle pulse when abort terminates LOAD/RUN
period_cnt  output  PCNT_W  completed periods since last accepted request

Behaviour:
- Reset (rst high at rising clk): state=IDLE, start_q=0, limit_q=0, periodic_q=0, period_cnt=0, aborted=0. Decoded outputs follow: load=0, enab=0, done=0, busy=0, cnt_in=0. req_ready=0 while rst is high. rst has no effect between edges.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: req_ready=1. On req_valid&req_ready, capture start/limit/periodic into start_q/limit_q/periodic_q, clear period_cnt, and go to LOAD. abort is ignored in IDLE.
- LOAD: load=1, cnt_in=start_q, for exactly one cycle, then go to RUN. cnt_out equals start_q from the first RUN cycle.
- RUN: enab = tick & (cnt_out != limit_q), combinational. When cnt_out==limit_q, enab=0 and the next state is DONE.
- DONE: done=1 for one cycle and period_cnt increments, saturating at 2^PCNT_W-1. Next state is LOAD if periodic_q & ~abort; otherwise IDLE.
- abort in LOAD or RUN: next state is IDLE, aborted=1 for one cycle (registered), no done, load/enab deasserted from the next cycle. In the abort cycle itself, enab still follows the RUN rule.
- abort in DONE: done still pulses, the reload is suppressed and the next state is IDLE. aborted is not pulsed.
- Arithmetic: the counter wraps modulo 2^WIDTH. The number of enab cycles per period is (limit_q - start_q) mod 2^WIDTH. start==limit gives zero enab cycles, and DONE follows the first RUN cycle.
- cnt_in holds start_q in all states. load is never asserted together with enab.
- Latency: with tick continuously high, for accept at cycle T0, done is at T0+3+N, where N = enab count.

Decomposition:
- Shared include/package: state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3) and the default WIDTH.
- One natural sub-module: sat_cnt, a parameterised saturating incrementer with synchronous clear, used for period_cnt.
- FSM, capture registers and output decode live in the top.

Test Plan:
- One-shot, tick=1, start=3 limit=7: accept at T0; load at T1; enab high T2–T5 (cnt 3→7); done at T7; IDLE and req_ready=1 at T8; period_cnt=1.
- Wrap, start=30 limit=2: exactly 4 enab cycles (30,31,0,1→2); done pulses once; period_cnt=1.
- start=limit=9: zero enab cycles; done at T3; no load/enab overlap.
- Periodic, start=0 limit=3, tick=1: three consecutive done pulses, each preceded by a load and 3 enab cycles; period_cnt=3. Then abort mid-RUN: aborted pulse, busy=0 next cycle, no further done.
- tick every 3rd cycle, start=0 limit=2: enab asserted only on tick cycles, 2 total; done after the second increment.
- rst held for one cycle during RUN (cnt_out=5): next cycle state=IDLE, load/enab/done=0, period_cnt=0, req_ready=1 once rst falls. rst pulsed between edges has no effect.

Source files
------------

// File: rtl/cnt_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cnt_seq_ctrl_pkg
// Shared definitions for the counter sequencing controller:
//   - default counter / period-counter widths
//   - FSM state encoding (IDLE, LOAD, RUN, DONE)
// ----------------------------------------------------------------------------
package cnt_seq_ctrl_pkg;

    localparam int DEF_WIDTH  = 5;
    localparam int DEF_PCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// cnt_seq_ctrl_if
// Timing-request handshake into the controller.
//   req_valid    : request present                 (master -> slave)
//   req_ready    : controller can accept a request (slave -> master)
//   req_start    : value loaded into the counter   (master -> slave)
//   req_limit    : terminal count value            (master -> slave)
//   req_periodic : 1 = reload and repeat, 0 = one-shot
// ----------------------------------------------------------------------------
interface cnt_seq_ctrl_if
    import cnt_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_start;
    logic [WIDTH-1:0] req_limit;
    logic             req_periodic;

    modport master (
        output req_valid, req_start, req_limit, req_periodic,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_start, req_limit, req_periodic,
        output req_ready
    );
endinterface

// File: rtl/cnt_seq_ctrl_sat_cnt.sv
// ----------------------------------------------------------------------------
// sat_cnt
// Saturating up-counter with synchronous clear; clear wins over increment.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : return to zero
//   inc_i    : increment, holding at all-ones
//   cnt_o    : current count
// ----------------------------------------------------------------------------
module sat_cnt
    import cnt_seq_ctrl_pkg::*;
#(
    parameter int W = DEF_PCNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/cnt_seq_ctrl.sv
// ----------------------------------------------------------------------------
// cnt_seq_ctrl
// Upstream sequencer for a loadable up-counter stage. Accepts a timing request,
// loads the counter, enables it on tick strobes until it reaches the limit,
// then pulses done and either returns to IDLE or reloads (periodic mode).
//   clk, rst      : clock, synchronous active-high reset
//   req           : request handshake (slave side)
//   abort_i       : stop the current operation (ignored in IDLE)
//   tick_i        : count strobe
//   cnt_out_i     : counter stage registered value
//   load_o        : counter load strobe (LOAD state)
//   enab_o        : counter increment enable
//   cnt_in_o      : counter load value (captured start)
//   busy_o        : not IDLE
//   done_o        : one-cycle pulse when the limit is reached
//   aborted_o     : one-cycle pulse after an abort in LOAD/RUN
//   period_cnt_o  : completed periods since last accepted request (saturating)
// ----------------------------------------------------------------------------
module cnt_seq_ctrl
    import cnt_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PCNT_W = DEF_PCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    cnt_seq_ctrl_if.slave     req,
    input  logic              abort_i,
    input  logic              tick_i,
    input  logic [WIDTH-1:0]  cnt_out_i,
    output logic              load_o,
    output logic              enab_o,
    output logic [WIDTH-1:0]  cnt_in_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [PCNT_W-1:0] period_cnt_o
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             periodic_q, periodic_d;
    logic             aborted_q, aborted_d;

    logic req_ready;
    logic accept;
    logic at_limit;

    // Ready is masked during reset so nothing is handed over on a reset edge.
    assign req_ready     = (state_q == IDLE) && !rst;
    assign req.req_ready = req_ready;
    assign accept        = req.req_valid && req_ready;
    assign at_limit      = (cnt_out_i == limit_q);

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        // Only an abort that cuts LOAD/RUN short is flagged; DONE completes.
        aborted_d  = abort_i && ((state_q == LOAD) || (state_q == RUN));

        if (accept) begin
            start_d    = req.req_start;
            limit_d    = req.req_limit;
            periodic_d = req.req_periodic;
        end

        unique case (state_q)
            IDLE: if (accept) state_d = LOAD;
            LOAD: state_d = abort_i ? IDLE : RUN;
            RUN: begin
                if (abort_i)       state_d = IDLE;
                else if (at_limit) state_d = DONE;
            end
            DONE: state_d = (periodic_q && !abort_i) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            start_q    <= '0;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            aborted_q  <= aborted_d;
        end
    end

    // Output decode; enab is combinational on tick and stops at the limit,
    // so the counter never passes limit_q.
    assign load_o    = (state_q == LOAD);
    assign enab_o    = (state_q == RUN) && tick_i && !at_limit;
    assign done_o    = (state_q == DONE);
    assign busy_o    = (state_q != IDLE);
    assign cnt_in_o  = start_q;
    assign aborted_o = aborted_q;

    sat_cnt #(.W(PCNT_W)) u_pcnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .inc_i (state_q == DONE),
        .cnt_o (period_cnt_o)
    );
endmodule
